// File: rtl/data_sram_bridge_pkg.sv
// Shared definitions for the data-SRAM bridge: FSM state encoding, the
// abort pattern returned on a watchdog timeout, and the byte-strobe width
// helper derived from the data width.
package data_sram_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } bridge_state_t;

    localparam logic [31:0] ABORT_PATTERN = 32'hDEAD_BEEF;

    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/data_sram_bridge_watchdog.sv
// bridge_watchdog: response-timeout counter for the data-SRAM bridge.
//   clk, rst      clock, synchronous active-low reset
//   clear         reload the counter to zero (request handshake)
//   count_en      count this cycle (bridge is waiting for a response)
//   expire        high during the TIMEOUT_CYC-th counted cycle
module bridge_watchdog #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // cnt holds the number of cycles already spent waiting, so the
    // TIMEOUT_CYC-th waiting cycle is the one that sees cnt == LAST.
    assign expire = count_en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count_en && !expire) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/data_sram_bridge.sv
// data_sram_bridge: converts the core's single-cycle SRAM-style data port
// into one valid/ready transaction per access on a variable-latency bus,
// stalling the pipeline while the transaction is outstanding.
//   core side : data_sram_en/wen/addr/wdata in, data_sram_rdata out
//   ctrl side : stallreq_for_mem out
//   mem side  : mem_req_* out (valid/ready handshake), mem_resp_* in
//   status    : timeout_err, sticky until reset
module data_sram_bridge
    import data_sram_bridge_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          data_sram_en,
    input  logic [strb_width(DATA_W)-1:0] data_sram_wen,
    input  logic [ADDR_W-1:0]             data_sram_addr,
    input  logic [DATA_W-1:0]             data_sram_wdata,
    output logic [DATA_W-1:0]             data_sram_rdata,
    output logic                          stallreq_for_mem,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic                          mem_req_wr,
    output logic [strb_width(DATA_W)-1:0] mem_req_wstrb,
    output logic [ADDR_W-1:0]             mem_req_addr,
    output logic [DATA_W-1:0]             mem_req_wdata,
    input  logic                          mem_resp_valid,
    input  logic [DATA_W-1:0]             mem_resp_rdata,
    output logic                          timeout_err
);

    localparam int STRB_W = strb_width(DATA_W);
    localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(ABORT_PATTERN);

    bridge_state_t     state;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic              req_wr;
    logic              req_valid;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              wd_expire;

    bridge_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear    ((state == ST_REQ) && mem_req_ready),
        .count_en (state == ST_WAIT),
        .expire   (wd_expire)
    );

    // IDLE follows the core strobe combinationally so EX holds in the same
    // cycle; DONE releases the stall so the pipeline advances. Gated by rst
    // so nothing is requested while reset is held.
    assign stallreq_for_mem = rst && ((state == ST_IDLE) ? data_sram_en
                                                         : (state != ST_DONE));

    assign mem_req_valid   = req_valid;
    assign mem_req_wr      = req_wr;
    assign mem_req_wstrb   = req_wstrb;
    assign mem_req_addr    = req_addr;
    assign mem_req_wdata   = req_wdata;
    assign data_sram_rdata = rdata_q;
    assign timeout_err     = err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            req_addr  <= '0;
            req_wdata <= '0;
            req_wstrb <= '0;
            req_wr    <= 1'b0;
            req_valid <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (data_sram_en) begin
                        req_addr  <= data_sram_addr;
                        req_wdata <= data_sram_wdata;
                        req_wstrb <= data_sram_wen;
                        req_wr    <= |data_sram_wen;
                        req_valid <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        req_valid <= 1'b0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        if (!req_wr) rdata_q <= mem_resp_rdata;
                        state <= ST_DONE;
                    end else if (wd_expire) begin
                        err_q <= 1'b1;
                        if (!req_wr) rdata_q <= ABORT_DATA;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Core inputs still show the finished request here.
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_bridge.sv
module tb_data_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq_for_mem;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wr;
    logic [3:0]  mem_req_wstrb;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        timeout_err;

    int vectors = 0;
    int errors  = 0;
    int hs_count = 0;

    data_sram_bridge #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .data_sram_en     (data_sram_en),
        .data_sram_wen    (data_sram_wen),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata),
        .data_sram_rdata  (data_sram_rdata),
        .stallreq_for_mem (stallreq_for_mem),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_wr       (mem_req_wr),
        .mem_req_wstrb    (mem_req_wstrb),
        .mem_req_addr     (mem_req_addr),
        .mem_req_wdata    (mem_req_wdata),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_rdata   (mem_resp_rdata),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_req_valid && mem_req_ready) hs_count++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'h0;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
        mem_req_ready   = 1'b0;
        mem_resp_valid  = 1'b0;
        mem_resp_rdata  = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        tick(); tick();
        #1;
        vectors++;
        if ({stallreq_for_mem, mem_req_valid, mem_req_wr, mem_req_wstrb, timeout_err} !== 8'h00
            || data_sram_rdata !== 32'h0 || mem_req_addr !== 32'h0 || mem_req_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: stall=%b valid=%b wr=%b strb=%h err=%b rdata=%h addr=%h wdata=%h, all required 0",
                     stallreq_for_mem, mem_req_valid, mem_req_wr, mem_req_wstrb, timeout_err,
                     data_sram_rdata, mem_req_addr, mem_req_wdata);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_read_zero_wait();
        int hs0 = hs_count;
        data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = 32'h8000_0010;
        mem_req_ready = 1'b1;
        #1;
        vectors++;
        if ({stallreq_for_mem, mem_req_valid} !== 2'b10) begin
            errors++; $display("FAIL rd_idle stall/valid: got %b required 10", {stallreq_for_mem, mem_req_valid});
        end
        tick();  // REQ
        vectors++;
        if ({stallreq_for_mem, mem_req_valid, mem_req_wr} !== 3'b110 || mem_req_addr !== 32'h8000_0010) begin
            errors++; $display("FAIL rd_req: stall/valid/wr=%b addr=%h required 110 80000010",
                               {stallreq_for_mem, mem_req_valid, mem_req_wr}, mem_req_addr);
        end
        tick();  // WAIT
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1234_5678;
        #1;
        vectors++;
        if ({stallreq_for_mem, mem_req_valid} !== 2'b10) begin
            errors++; $display("FAIL rd_wait stall/valid: got %b required 10", {stallreq_for_mem, mem_req_valid});
        end
        tick();  // DONE
        mem_resp_valid = 1'b0;
        #1;
        vectors++;
        if (stallreq_for_mem !== 1'b0) begin
            errors++; $display("FAIL rd_done_stall: got %b required 0", stallreq_for_mem);
        end
        data_sram_en = 1'b0;
        tick();  // IDLE, MEM samples rdata
        vectors++;
        if (data_sram_rdata !== 32'h1234_5678 || stallreq_for_mem !== 1'b0) begin
            errors++; $display("FAIL rd_rdata: rdata=%h stall=%b required 12345678 0", data_sram_rdata, stallreq_for_mem);
        end
        vectors++;
        if (hs_count - hs0 !== 1) begin
            errors++; $display("FAIL rd_handshakes: got %0d required 1", hs_count - hs0);
        end
    endtask

    task automatic test_write_delayed_ready();
        int hs0 = hs_count;
        data_sram_en = 1'b1; data_sram_wen = 4'hF; data_sram_addr = 32'h8000_0020;
        data_sram_wdata = 32'hCAFE_F00D; mem_req_ready = 1'b0;
        tick();  // REQ
        for (int i = 0; i < 4; i++) begin
            // Scramble the core inputs: the request must come from the latches.
            data_sram_addr = 32'h5555_0000 + i; data_sram_wdata = 32'h0; data_sram_wen = 4'h1;
            #1;
            vectors++;
            if ({stallreq_for_mem, mem_req_valid, mem_req_wr, mem_req_wstrb} !== 7'b111_1111
                || mem_req_addr !== 32'h8000_0020 || mem_req_wdata !== 32'hCAFE_F00D) begin
                errors++;
                $display("FAIL wr_hold[%0d]: stall/valid/wr/strb=%b addr=%h wdata=%h required 1111111 80000020 cafef00d",
                         i, {stallreq_for_mem, mem_req_valid, mem_req_wr, mem_req_wstrb}, mem_req_addr, mem_req_wdata);
            end
            tick();
        end
        mem_req_ready = 1'b1;
        tick();  // WAIT
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0BAD_0BAD;
        tick();  // DONE
        mem_resp_valid = 1'b0;
        #1;
        vectors++;
        if (stallreq_for_mem !== 1'b0 || data_sram_rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL wr_done: stall=%b rdata=%h required 0 12345678", stallreq_for_mem, data_sram_rdata);
        end
        data_sram_en = 1'b0; data_sram_wen = 4'h0;
        tick();
        vectors++;
        if (hs_count - hs0 !== 1) begin
            errors++; $display("FAIL wr_handshakes: got %0d required 1", hs_count - hs0);
        end
    endtask

    task automatic test_back_to_back();
        int hs0 = hs_count;
        data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = 32'h0000_0100;
        mem_req_ready = 1'b1;
        tick();  // REQ
        tick();  // WAIT
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1122_3344;
        tick();  // DONE, core still presents the old read
        mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
        #1;
        vectors++;
        if ({stallreq_for_mem, mem_req_valid} !== 2'b00) begin
            errors++; $display("FAIL b2b_done: stall/valid=%b required 00", {stallreq_for_mem, mem_req_valid});
        end
        tick();  // IDLE: next instruction, byte write
        data_sram_en = 1'b1; data_sram_wen = 4'b0100; data_sram_addr = 32'h0000_0104;
        data_sram_wdata = 32'hAABB_CCDD;
        #1;
        vectors++;
        if ({stallreq_for_mem, mem_req_valid} !== 2'b10 || data_sram_rdata !== 32'h1122_3344) begin
            errors++; $display("FAIL b2b_idle: stall/valid=%b rdata=%h required 10 11223344",
                               {stallreq_for_mem, mem_req_valid}, data_sram_rdata);
        end
        tick();  // REQ
        vectors++;
        if ({mem_req_valid, mem_req_wr, mem_req_wstrb} !== 6'b11_0100 || mem_req_addr !== 32'h0000_0104
            || mem_req_wdata !== 32'hAABB_CCDD) begin
            errors++; $display("FAIL b2b_wr_req: valid/wr/strb=%b addr=%h wdata=%h required 110100 00000104 aabbccdd",
                               {mem_req_valid, mem_req_wr, mem_req_wstrb}, mem_req_addr, mem_req_wdata);
        end
        tick();  // WAIT
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'hFFFF_FFFF;
        tick();  // DONE
        mem_resp_valid = 1'b0; data_sram_en = 1'b0; data_sram_wen = 4'h0;
        tick(); tick();
        vectors++;
        if (hs_count - hs0 !== 2 || data_sram_rdata !== 32'h1122_3344) begin
            errors++; $display("FAIL b2b_handshakes: count=%0d rdata=%h required 2 11223344", hs_count - hs0, data_sram_rdata);
        end
    endtask

    task automatic test_timeout();
        data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = 32'h0000_0200;
        mem_req_ready = 1'b1;
        tick();  // REQ
        tick();  // WAIT 1
        mem_req_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            #1;
            vectors++;
            if ({stallreq_for_mem, timeout_err} !== 2'b10) begin
                errors++; $display("FAIL to_wait[%0d]: stall/err=%b required 10", i, {stallreq_for_mem, timeout_err});
            end
            tick();
        end
        // now in DONE
        vectors++;
        if ({stallreq_for_mem, timeout_err} !== 2'b01 || data_sram_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL to_done: stall/err=%b rdata=%h required 01 deadbeef",
                               {stallreq_for_mem, timeout_err}, data_sram_rdata);
        end
        data_sram_en = 1'b0;
        tick();
        // a good read afterwards; flag must stay set
        data_sram_en = 1'b1; data_sram_addr = 32'h0000_0300; mem_req_ready = 1'b1;
        tick(); tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h600D_600D;
        tick();
        mem_resp_valid = 1'b0; data_sram_en = 1'b0;
        tick();
        vectors++;
        if (timeout_err !== 1'b1 || data_sram_rdata !== 32'h600D_600D) begin
            errors++; $display("FAIL to_sticky: err=%b rdata=%h required 1 600d600d", timeout_err, data_sram_rdata);
        end
    endtask

    task automatic test_reset_in_wait();
        int hs0;
        data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = 32'h0000_0400;
        mem_req_ready = 1'b1;
        tick(); tick();  // WAIT
        hs0 = hs_count;
        mem_req_ready = 1'b0; data_sram_en = 1'b0; rst = 1'b0;
        tick();
        rst = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0BAD_CAFE;
        #1;
        vectors++;
        if ({stallreq_for_mem, mem_req_valid, timeout_err} !== 3'b000 || data_sram_rdata !== 32'h0
            || mem_req_addr !== 32'h0) begin
            errors++; $display("FAIL rstwait_outputs: stall/valid/err=%b rdata=%h addr=%h required 000 0 0",
                               {stallreq_for_mem, mem_req_valid, timeout_err}, data_sram_rdata, mem_req_addr);
        end
        tick();
        mem_resp_valid = 1'b0;
        tick();
        vectors++;
        if ({stallreq_for_mem, mem_req_valid} !== 2'b00 || data_sram_rdata !== 32'h0 || hs_count != hs0) begin
            errors++; $display("FAIL rstwait_stray: stall/valid=%b rdata=%h hs=%0d required 00 0 0",
                               {stallreq_for_mem, mem_req_valid}, data_sram_rdata, hs_count - hs0);
        end
    endtask

    task automatic test_reset_with_en();
        int seen_valid = 0;
        rst = 1'b0; data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = 32'h0000_0500;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_req_valid || stallreq_for_mem) seen_valid++;
        end
        vectors++;
        if (seen_valid != 0) begin
            errors++; $display("FAIL rsten_quiet: cycles with valid/stall=%0d required 0", seen_valid);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({stallreq_for_mem, mem_req_valid} !== 2'b10) begin
            errors++; $display("FAIL rsten_release: stall/valid=%b required 10", {stallreq_for_mem, mem_req_valid});
        end
        tick();
        vectors++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_0500) begin
            errors++; $display("FAIL rsten_req: valid=%b addr=%h required 1 00000500", mem_req_valid, mem_req_addr);
        end
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'hA5A5_5A5A;
        tick();
        mem_resp_valid = 1'b0; data_sram_en = 1'b0;
        tick();
        vectors++;
        if (data_sram_rdata !== 32'hA5A5_5A5A || stallreq_for_mem !== 1'b0) begin
            errors++; $display("FAIL rsten_rdata: rdata=%h stall=%b required a5a55a5a 0", data_sram_rdata, stallreq_for_mem);
        end
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_delayed_ready();
        test_back_to_back();
        test_timeout();
        test_reset_in_wait();
        test_reset_with_en();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete, required completion before 100000");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/data_sram_bridge.md
Name: data_sram_bridge

Overview:
- Responder end of the core's data-SRAM port.
- Accepts the core's single-cycle SRAM-style requests (en/wen/addr/wdata, rdata expected the following cycle) and turns each into one transaction on a valid/ready external memory bus with variable latency.
- Raises a stall request to the pipeline controller while a transaction is outstanding, so the EX/MEM stages see SRAM-like timing.
- Includes a response-timeout watchdog with a sticky error flag.

Parameters:
- ADDR_W, 32, address width of the core and memory buses
- DATA_W, 32, data width; byte strobes are DATA_W/8 bits wide
- TIMEOUT_CYC, 255, maximum cycles spent in WAIT before an aborted response; must be ≥ 1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- data_sram_en  in  1  core request strobe
- data_sram_wen  in  DATA_W/8  byte write enables; all-zero means read
- data_sram_addr  in  ADDR_W  byte address
- data_sram_wdata  in  DATA_W  write data
- data_sram_rdata  out  DATA_W  read data returned to MEM stage
- stallreq_for_mem  out  1  stall request to CTRL
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  request accepted
- mem_req_wr  out  1  1 = write
- mem_req_wstrb  out  DATA_W/8  byte strobes
- mem_req_addr  out  ADDR_W  address, passed through unmodified
- mem_req_wdata  out  DATA_W  write data
- mem_resp_valid  in  1  response or write acknowledge; the bridge always accepts it
- mem_resp_rdata  in  DATA_W  read data
- timeout_err  out  1  sticky; set on watchdog expiry

Behaviour:
- Reset: rst==0 at a rising edge forces the following.
  - State = IDLE; request latches = 0; data_sram_rdata = 0; timeout_err = 0; wait counter = 0.
  - All outputs low or zero.
  - Reset mid-transaction drops the outstanding transaction. Any later mem_resp_valid arriving in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - stallreq_for_mem = data_sram_en (combinational), so the EX stage holds on the same cycle.
  - If data_sram_en = 1: latch addr, wdata and wen; set wr = |wen; go to REQ.
- REQ:
  - mem_req_valid = 1, driven from the latched fields only (never directly from the core inputs); stallreq_for_mem = 1.
  - When mem_req_ready = 1: go to WAIT and clear the counter. Otherwise stay in REQ with the request held stable.
- WAIT:
  - stallreq_for_mem = 1; the counter increments each cycle.
  - If mem_resp_valid = 1: capture mem_resp_rdata into data_sram_rdata when the transaction is a read (writes leave it unchanged); go to DONE.
  - Otherwise, if the counter reaches TIMEOUT_CYC: set timeout_err, load data_sram_rdata = 32'hDEAD_BEEF for reads, go to DONE.
  - mem_resp_valid arriving in the same cycle the request handshakes is not legal on the bus and is not required to be handled.
- DONE:
  - stallreq_for_mem = 0; the pipeline advances at the end of this cycle.
  - The core inputs still carry the old request; they are ignored. Go to IDLE unconditionally.
- Latency:
  - Minimum stall is 3 cycles: IDLE request, REQ handshake, WAIT response with zero-wait memory. DONE follows.
  - data_sram_rdata is valid from the cycle after DONE, i.e. when the MEM stage samples it.
  - data_sram_rdata holds its value until the next read response.
- Back-to-back: a new en in the cycle after DONE starts the next transaction. There is no request overlap and at most one outstanding transaction.
- A write with a partial wen (e.g. 4'b0011) forwards the strobes unchanged. The bridge does no byte alignment.
- timeout_err clears only on reset.

Decomposition:
- Shared package / defines: FSM state encoding (2-bit), DEADBEEF abort pattern, and the strobe width macro derived from DATA_W.
- Sub-module: bridge_watchdog, a loadable counter that raises an expiry pulse at TIMEOUT_CYC.
- The FSM and datapath latches stay in the top.

Test Plan:
- Read, zero-wait memory: en=1, wen=0, addr=0x8000_0010; ready=1; resp next cycle with 0x1234_5678 -> stall high for exactly 3 cycles, low in DONE; rdata=0x1234_5678 the cycle after DONE.
- Write, ready delayed 4 cycles: wen=4'hF, wdata=0xCAFE_F00D -> mem_req fields stable across all 4 cycles; wr=1, wstrb=4'hF; rdata unchanged.
- Back-to-back read then byte write (wen=4'b0100): the second request is issued only after DONE. Exactly two mem_req handshakes occur, with no duplicate issue of the held request.
- Timeout, TIMEOUT_CYC=8, no response: timeout_err rises after 8 WAIT cycles; rdata=0xDEAD_BEEF; stall drops in DONE; the flag stays set through later good transactions.
- rst driven low while in WAIT, then a stray mem_resp_valid -> IDLE, all outputs 0, the stray response ignored, stallreq stays 0.
- rst held low while data_sram_en=1: no mem_req_valid is ever asserted; release of rst with en=1 starts a normal transaction the next cycle.
